alu_arbiter: RTL

Two-requester arbiter that shares one 32-bit RV32I ALU between independent clients, e.g. the execute stage and the branch-target/compare unit. It instantiates the `alu` datapath internally and accepts valid/ready operand requests. It grants them round-robin and returns a registered result `{y, zero}` on a per-requester response channel with a one-deep output buffer.

---
 rtl/alu_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single 32-bit RV32I ALU between two independent requesters, for
// example the execute stage and the branch-target/compare unit. Requests use
// a valid/ready handshake and are granted round-robin. Each accepted request
// produces a registered {y, zero} result. The result waits in a one-entry
// output buffer until the requester that owns it consumes it on its own
// response channel.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   rN_valid / rN_ready           operand request handshake, N = 0, 1
//   rN_a, rN_b, rN_op             operands and 4-bit ALU opcode
//   rN_rsp_valid / rN_rsp_ready   response handshake, N = 0, 1
//   rN_rsp_y, rN_rsp_zero         buffered result and result-is-zero flag
//
// This file also contains the combinational `alu` datapath used internally.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// alu
//
// Purely combinational RV32I integer ALU.
// Ports:
//   a, b  32-bit operands
//   op    opcode:
//           0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR,
//           5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
//   y     result; opcodes 10-15 produce zero rather than flagging an error
//   zero  high when y is zero
// ---------------------------------------------------------------------------
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] y,
    output logic        zero
);

    // Opcode decode. Shifts take their amount from b[4:0] only. The two set-
    // less-than opcodes differ only in whether the comparison is signed.
    always_comb begin
        y = 32'd0;
        case (op)
            4'd0:    y = a + b;
            4'd1:    y = a - b;
            4'd2:    y = a & b;
            4'd3:    y = a | b;
            4'd4:    y = a ^ b;
            4'd5:    y = a << b[4:0];
            4'd6:    y = a >> b[4:0];
            4'd7:    y = $signed(a) >>> b[4:0];
            4'd8:    y = {31'd0, ($signed(a) < $signed(b))};
            4'd9:    y = {31'd0, (a < b)};
            default: y = 32'd0;
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

module alu_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [3:0]  r0_op,

    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [3:0]  r1_op,

    output logic        r0_rsp_valid,
    input  logic        r0_rsp_ready,
    output logic [31:0] r0_rsp_y,
    output logic        r0_rsp_zero,

    output logic        r1_rsp_valid,
    input  logic        r1_rsp_ready,
    output logic [31:0] r1_rsp_y,
    output logic        r1_rsp_zero
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] buf_y;
    logic        buf_zero;
    logic        owner;
    logic        last_grant;

    logic        grant;
    logic        owner_rsp_ready;
    logic        can_accept;
    logic        accept;
    logic        drain;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_y;
    logic        alu_zero;

    // The buffer can take a new result when it is empty, or when the current
    // result is being consumed in this same cycle. The second case lets a
    // drain and an accept overlap, so a result can be produced every cycle.
    // A non-owner cannot get past a stalled owner (head-of-line blocking).
    // Ready is forced low while rst is asserted, so no handshake completes
    // during the reset cycle.
    always_comb begin
        owner_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;
        can_accept      = !rst && ((state == EMPTY) || owner_rsp_ready);
        drain           = (state == FULL) && owner_rsp_ready;
    end

    // Round-robin choice. A lone requester always wins. On a tie, the
    // requester that was not granted last time wins. last_grant resets to 1,
    // so requester 0 wins the first tie.
    always_comb begin
        grant = 1'b0;
        if (r0_valid && r1_valid) begin
            grant = ~last_grant;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
    end

    assign r0_ready = can_accept && (grant == 1'b0);
    assign r1_ready = can_accept && (grant == 1'b1);
    assign accept   = (r0_ready && r0_valid) || (r1_ready && r1_valid);

    // The granted requester's operands drive the shared ALU.
    always_comb begin
        alu_a  = grant ? r1_a  : r0_a;
        alu_b  = grant ? r1_b  : r0_b;
        alu_op = grant ? r1_op : r0_op;
    end

    alu u_alu (
        .a    (alu_a),
        .b    (alu_b),
        .op   (alu_op),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Buffer state register. Reset empties the buffer, which discards any
    // pending result immediately, without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. An accept always leaves the buffer full, even when it
    // overlaps a drain. A drain on its own empties the buffer.
    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = FULL;
        end else if (drain) begin
            next_state = EMPTY;
        end
    end

    // Result capture and round-robin history. These registers change only on
    // an accepted request, so the buffer stays stable while the owner stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_y      <= 32'd0;
            buf_zero   <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            buf_y      <= alu_y;
            buf_zero   <= alu_zero;
            owner      <= grant;
            last_grant <= grant;
        end
    end

    // Both response channels carry the buffer contents. Only the owner's
    // valid is raised, so consumers must qualify the data with rsp_valid.
    assign r0_rsp_valid = (state == FULL) && (owner == 1'b0);
    assign r1_rsp_valid = (state == FULL) && (owner == 1'b1);
    assign r0_rsp_y     = buf_y;
    assign r0_rsp_zero  = buf_zero;
    assign r1_rsp_y     = buf_y;
    assign r1_rsp_zero  = buf_zero;

endmodule
